iic_cfg_sequencer: RTL and testbench



---
 rtl/iic_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/iic_cfg_sequencer.sv | 123 ++++++++++++
 tb/tb_iic_cfg_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared types and timing defaults for the I2C configuration path.
// The sequencer and the I2C config top both draw their clock ratio from here.
package iic_pkg;

    typedef enum logic [2:0] {
        PWRUP     = 3'd0,
        TRIG      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4,
        DONE      = 3'd5,
        FAIL      = 3'd6
    } seq_state_t;

    // clk_8m cycles per clk_i period of the I2C config top
    localparam int CLK_I_RATIO  = 20;
    localparam int MIN_TRIG_CYC = 2 * CLK_I_RATIO;

    localparam int DEF_PWRUP_CYC    = 8000;
    localparam int DEF_TRIG_CYC     = 64;
    localparam int DEF_ACK_TIMEOUT  = 200;
    localparam int DEF_DONE_TIMEOUT = 800000;
    localparam int DEF_RETRY_GAP    = 8000;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_CNT_W        = 20;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser for slow-domain status inputs.
// Synchronous active-low reset clears both stages.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Power-up / retry sequencer that triggers the I2C config top and
// watches its busy flag for start and completion within timeouts.
module iic_cfg_sequencer
    import iic_pkg::*;
#(
    parameter int PWRUP_CYC    = DEF_PWRUP_CYC,
    parameter int TRIG_CYC     = DEF_TRIG_CYC,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
    parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT,
    parameter int RETRY_GAP    = DEF_RETRY_GAP,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk_8m,
    input  logic       rst_n,
    input  logic       cfg_req,
    input  logic       IIC_config_busy,
    output logic       IIC_en_tri,
    output logic       cfg_done,
    output logic       cfg_fail,
    output logic [1:0] attempt_cnt,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_TRIG  = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] LD_ACK   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_DONE  = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(RETRY_GAP - 1);
    localparam logic [1:0]       LAST_TRY = 2'(MAX_RETRY);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_s;
    logic             busy_prev;
    logic             rise;
    logic             fall;
    logic             expired;
    logic             edge_ok;

    sync_2ff u_sync (
        .clk   (clk_8m),
        .rst_n (rst_n),
        .d     (IIC_config_busy),
        .q     (busy_s)
    );

    assign rise      = busy_s & ~busy_prev;
    assign fall      = ~busy_s & busy_prev;
    assign expired   = (cnt == '0);
    assign edge_ok   = (state == WAIT_ACK) ? rise : fall;
    assign seq_state = state;

    always_ff @(posedge clk_8m) begin
        if (!rst_n) begin
            state       <= PWRUP;
            cnt         <= LD_PWRUP;
            busy_prev   <= 1'b0;
            IIC_en_tri  <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_fail    <= 1'b0;
            attempt_cnt <= 2'd0;
        end else begin
            busy_prev <= busy_s;
            if (!expired) begin
                cnt <= cnt - 1'b1;
            end
            unique case (state)
                PWRUP, GAP: begin
                    if (expired) begin
                        state      <= TRIG;
                        cnt        <= LD_TRIG;
                        IIC_en_tri <= 1'b1;
                    end
                end
                TRIG: begin
                    if (expired) begin
                        state      <= WAIT_ACK;
                        cnt        <= LD_ACK;
                        IIC_en_tri <= 1'b0;
                    end
                end
                // an edge seen on the expiry cycle still counts as success
                WAIT_ACK, WAIT_DONE: begin
                    if (edge_ok) begin
                        if (state == WAIT_ACK) begin
                            state <= WAIT_DONE;
                            cnt   <= LD_DONE;
                        end else begin
                            state    <= DONE;
                            cfg_done <= 1'b1;
                        end
                    end else if (expired) begin
                        if (attempt_cnt >= LAST_TRY) begin
                            state    <= FAIL;
                            cfg_fail <= 1'b1;
                        end else begin
                            state       <= GAP;
                            cnt         <= LD_GAP;
                            attempt_cnt <= attempt_cnt + 2'd1;
                        end
                    end
                end
                DONE, FAIL: begin
                    if (cfg_req) begin
                        state       <= TRIG;
                        cnt         <= LD_TRIG;
                        IIC_en_tri  <= 1'b1;
                        cfg_done    <= 1'b0;
                        cfg_fail    <= 1'b0;
                        attempt_cnt <= 2'd0;
                    end
                end
                default: begin
                    state      <= PWRUP;
                    cnt        <= LD_PWRUP;
                    IIC_en_tri <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// Bench for iic_cfg_sequencer: directed scenarios plus randomized busy
// responses, checked every cycle against a deadline-based reference model.
module tb_iic_cfg_sequencer;

    localparam int P  = 10;
    localparam int T  = 4;
    localparam int A  = 8;
    localparam int D  = 20;
    localparam int G  = 5;
    localparam int MR = 2;

    localparam int M_PWR  = 0;
    localparam int M_TRIG = 1;
    localparam int M_ACK  = 2;
    localparam int M_WDN  = 3;
    localparam int M_GAP  = 4;
    localparam int M_DONE = 5;
    localparam int M_FAIL = 6;

    logic       clk_8m  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       cfg_req = 1'b0;
    logic       busy    = 1'b0;
    logic       en;
    logic       done;
    logic       fail;
    logic [1:0] att;
    logic [2:0] st;

    int tests = 0;
    int fails = 0;

    // reference model state: phase, absolute deadline cycle, tries
    int       cyc = 0;
    int       ph = M_PWR;
    int       deadline = 0;
    int       tries = 0;
    bit       m_en = 0;
    bit       m_done = 0;
    bit       m_fail = 0;
    bit [2:0] h = 3'b000;

    // busy responder: pulse from rd to rd+hold cycles after trigger fall
    int rd = 3;
    int hold = 10;
    int age = 1000000;

    always #5 clk_8m = ~clk_8m;

    iic_cfg_sequencer #(
        .PWRUP_CYC    (P),
        .TRIG_CYC     (T),
        .ACK_TIMEOUT  (A),
        .DONE_TIMEOUT (D),
        .RETRY_GAP    (G),
        .MAX_RETRY    (MR),
        .CNT_W        (20)
    ) dut (
        .clk_8m          (clk_8m),
        .rst_n           (rst_n),
        .cfg_req         (cfg_req),
        .IIC_config_busy (busy),
        .IIC_en_tri      (en),
        .cfg_done        (done),
        .cfg_fail        (fail),
        .attempt_cnt     (att),
        .seq_state       (st)
    );

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
        end
    endfunction

    task automatic start_trig();
        ph       = M_TRIG;
        deadline = cyc + T;
        m_en     = 1;
    endtask

    task automatic attempt_failed();
        if (tries < MR) begin
            tries++;
            ph       = M_GAP;
            deadline = cyc + G;
        end else begin
            ph     = M_FAIL;
            m_fail = 1;
        end
    endtask

    // h[0] newest raw sample; synchronised level lags two samples
    task automatic model_edge(input bit r, input bit q, input bit b);
        bit rise;
        bit fall;
        if (!r) begin
            ph       = M_PWR;
            deadline = cyc + P;
            tries    = 0;
            m_en     = 0;
            m_done   = 0;
            m_fail   = 0;
            h        = 3'b000;
            return;
        end
        rise = h[1] && !h[2];
        fall = !h[1] && h[2];
        case (ph)
            M_PWR, M_GAP: if (cyc == deadline) start_trig();
            M_TRIG: begin
                if (cyc == deadline) begin
                    ph       = M_ACK;
                    deadline = cyc + A;
                    m_en     = 0;
                end
            end
            M_ACK: begin
                if (rise) begin
                    ph       = M_WDN;
                    deadline = cyc + D;
                end else if (cyc == deadline) begin
                    attempt_failed();
                end
            end
            M_WDN: begin
                if (fall) begin
                    ph     = M_DONE;
                    m_done = 1;
                end else if (cyc == deadline) begin
                    attempt_failed();
                end
            end
            default: begin
                if (q) begin
                    m_done = 0;
                    m_fail = 0;
                    tries  = 0;
                    start_trig();
                end
            end
        endcase
        h = {h[1:0], b};
    endtask

    task automatic tick();
        bit prev_en;
        @(negedge clk_8m);
        busy = (age >= rd) && (age < rd + hold);
        @(posedge clk_8m);
        cyc++;
        prev_en = m_en;
        model_edge(rst_n, cfg_req, busy);
        if (prev_en && !m_en) age = 0;
        else if (age < 1000000) age++;
        #1;
        chk("en", en, m_en);
        chk("done", done, m_done);
        chk("fail", fail, m_fail);
        chk("attempt", att, tries);
        chk("state", st, ph);
    endtask

    task automatic pulse_req();
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while (!(ph == M_DONE || ph == M_FAIL) && n < max) begin
            tick();
            n++;
        end
        chk("idle_bound", n < max, 1);
    endtask

    task automatic run_phase(input int p, input int max);
        int n = 0;
        while (ph != p && n < max) begin
            tick();
            n++;
        end
        chk("phase_bound", n < max, 1);
    endtask

    task automatic measure_rise(output int n);
        n = 0;
        while (en !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int w;

        // reset and power-up delay
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_en", en, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_att", att, 0);
        chk("rst_state", st, 0);
        rst_n = 1'b1;
        measure_rise(n);
        chk("first_rise", n, P);
        w = 0;
        while (en === 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("trig_width", w, T);
        run_idle(200);
        chk("nom_done", done, 1);
        chk("nom_att", att, 0);

        // re-request from DONE, then an ignored request mid-transfer
        hold = 15;
        age  = 1000000;
        pulse_req();
        chk("req_clears_done", done, 0);
        chk("req_trig", en, 1);
        run_phase(M_WDN, 100);
        pulse_req();
        chk("req_ignored", st, M_WDN);
        run_idle(200);
        chk("rereq_done", done, 1);

        // busy falls exactly on WAIT_DONE expiry: success
        hold = D;
        pulse_req();
        run_idle(200);
        chk("tie_done", done, 1);
        chk("tie_att", att, 0);

        // one cycle longer: every attempt times out
        hold = D + 1;
        pulse_req();
        run_idle(300);
        chk("late_fail", fail, 1);
        chk("late_att", att, MR);

        // no acknowledge: fall-to-rise spacing is timeout plus gap
        rd   = 100;
        hold = 10;
        age  = 1000000;
        pulse_req();
        while (en === 1'b1 && cyc < 100000) tick();
        n = 0;
        while (en !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("retry_spacing", n, A + G);
        run_idle(300);
        chk("noack_fail", fail, 1);
        chk("noack_att", att, MR);
        repeat (20) tick();
        chk("noack_quiet", en, 0);

        // busy stuck high after rising
        rd   = 2;
        hold = 100000;
        age  = 1000000;
        pulse_req();
        run_idle(400);
        chk("stuck_fail", fail, 1);

        // reset while waiting for busy to fall
        pulse_req();
        run_phase(M_WDN, 100);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_en", en, 0);
        chk("mid_rst_state", st, 0);
        rst_n = 1'b1;
        measure_rise(n);
        chk("rst_rise", n, P);
        run_idle(400);

        // randomized responses, stray requests and occasional resets
        for (int k = 0; k < 40; k++) begin
            rd   = $urandom_range(0, 8);
            hold = $urandom_range(1, 24);
            pulse_req();
            n = 0;
            while (!(ph == M_DONE || ph == M_FAIL) && n < 400) begin
                cfg_req = ($urandom_range(0, 15) == 0);
                rst_n   = ($urandom_range(0, 199) != 0);
                tick();
                n++;
            end
            cfg_req = 1'b0;
            rst_n   = 1'b1;
            if (!(ph == M_DONE || ph == M_FAIL)) run_idle(400);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
